// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  // Funct7 value that marks an OP (0110011) instruction as an M-extension op.
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath shared by multiply and divide.
// Multiply: {hi,lo} is the product accumulator, lo starts as the multiplier,
//           opnd holds the multiplicand; add-then-shift-right each step.
// Divide:   hi is the partial remainder, lo starts as the dividend and fills
//           with quotient bits from the right, opnd holds the divisor.
// The *_nxt outputs are the values the registers take at the coming edge, so
// the sequencer can register the final result in the same cycle as the last step.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_nxt_o,
  output logic [XLEN-1:0] lo_nxt_o
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            div_q, div_d;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_sub;

  // Datapath registers; operation type is latched at init.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  // Load on init, otherwise one shift-add or restore-subtract step when enabled.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    rem_ge  = (rem_sh >= {1'b0, opnd_q});
    // Only used when rem_ge, where the difference is below the divisor.
    rem_sub = rem_sh[XLEN-1:0] - opnd_q;

    if (init_i) begin
      hi_d  = '0;
      div_d = div_i;
      if (div_i) begin
        lo_d   = a_i;
        opnd_d = b_i;
      end else begin
        lo_d   = b_i;
        opnd_d = a_i;
      end
    end else if (step_i) begin
      if (div_q) begin
        hi_d = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], rem_ge};
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign hi_nxt_o = hi_d;
  assign lo_nxt_o = lo_d;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, operand sign
// preparation, divide special cases and result sign fix-up around the
// iterative core.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              last_iter;
  logic              sign_a, sign_b;
  logic              a_signed, b_signed;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              neg_in;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic [XLEN-1:0]   mulh_neg;
  logic [XLEN-1:0]   final_res;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

  // Operand preparation: magnitudes for signed ops and the result-negate flag.
  always_comb begin
    sign_a   = op_a[XLEN-1];
    sign_b   = op_b[XLEN-1];
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_abs    = (a_signed && sign_a) ? (~op_a + 1'b1) : op_a;
    b_abs    = (b_signed && sign_b) ? (~op_b + 1'b1) : op_b;
    case (funct3)
      F3_MULH, F3_DIV:   neg_in = sign_a ^ sign_b;
      F3_MULHSU, F3_REM: neg_in = sign_a;
      default:           neg_in = 1'b0;
    endcase
  end

  // Divide special cases resolved at accept without iterating.
  always_comb begin
    div_zero    = f3_is_div(funct3) && (op_b == '0);
    div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else if (div_ovf) begin
      special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .init_i   (accept),
    .step_i   ((state_q == S_RUN) && !flush),
    .div_i    (f3_is_div(funct3)),
    .a_i      (a_abs),
    .b_i      (b_abs),
    .hi_nxt_o (hi_nxt),
    .lo_nxt_o (lo_nxt)
  );

  // Result selection and sign fix-up from the final-step core values.
  // High word of a 64-bit negate is ~hi plus the carry out of ~lo+1,
  // which occurs only when lo is zero.
  always_comb begin
    mulh_neg = ~hi_nxt + {{(XLEN-1){1'b0}}, (lo_nxt == '0)};
    case (f3_q)
      F3_MUL:                      final_res = lo_nxt;
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = neg_q ? mulh_neg : hi_nxt;
      F3_DIV, F3_DIVU:             final_res = neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
      default:                     final_res = neg_q ? (~hi_nxt + 1'b1) : hi_nxt;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = special ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (flush)          state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, latched op info and result register updates.
  always_comb begin
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (accept) begin
      cnt_d = '0;
      f3_d  = funct3;
      neg_d = neg_in;
      if (special) result_d = special_res;
    end else if ((state_q == S_RUN) && !flush) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) result_d = final_res;
    end
  end

  // Outputs; stall drops in DONE so the next stage captures the result.
  always_comb begin
    stall  = accept || (state_q == S_RUN);
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE) && !flush;
    result = result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drives one operation from the current cycle (caller is just after a
  // rising edge) and measures latency, result, stall cycles and the cycle
  // after done. Operands and funct3 are scrambled after accept.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output int stall_hi,
                       output logic stall_at_done, output logic done_next);
    lat = -1; res = '0; stall_hi = 0; stall_at_done = 1'b1; done_next = 1'b1;
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; flush = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (done) begin
        lat = c; res = result; stall_at_done = stall;
        break;
      end
      if (stall) stall_hi++;
      @(posedge clk); #1;
      start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    end
    @(posedge clk); #1;
    done_next = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat, sh; logic [31:0] res; logic sd, dn;
    do_op(3'b000, 32'd7, 32'hFFFFFFFD, lat, res, sh, sd, dn);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", lat); end
    checks++; if (res !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got %h exp ffffffeb", res); end
    checks++; if (sh !== 33) begin errors++; $display("FAIL mul_stall_cycles got %0d exp 33", sh); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL mul_stall_at_done got %b exp 0", sd); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL mul_done_one_cycle got %b exp 0", dn); end
  endtask

  task automatic test_mulh();
    int lat, sh; logic [31:0] res; logic sd, dn;
    do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, sh, sd, dn);
    checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_result got %h exp fffffffe", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mulhu_latency got %0d exp 33", lat); end
    do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, sh, sd, dn);
    checks++; if (res !== 32'h00000000) begin errors++; $display("FAIL mulh_result got %h exp 00000000", res); end
    do_op(3'b010, 32'hFFFFFFFF, 32'd2, lat, res, sh, sd, dn);
    checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu_result got %h exp ffffffff", res); end
    do_op(3'b001, 32'h80000000, 32'h00000003, lat, res, sh, sd, dn);
    checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulh_neg_result got %h exp fffffffe", res); end
  endtask

  task automatic test_div();
    int lat, sh; logic [31:0] res; logic sd, dn;
    do_op(3'b100, 32'hFFFFFFF9, 32'd2, lat, res, sh, sd, dn);
    checks++; if (res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_result got %h exp fffffffd", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    do_op(3'b110, 32'hFFFFFFF9, 32'd2, lat, res, sh, sd, dn);
    checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_result got %h exp ffffffff", res); end
    do_op(3'b101, 32'd100, 32'd7, lat, res, sh, sd, dn);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_result got %h exp 0000000e", res); end
    do_op(3'b111, 32'd100, 32'd7, lat, res, sh, sd, dn);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_result got %h exp 00000002", res); end
    do_op(3'b100, 32'd20, 32'hFFFFFFFD, lat, res, sh, sd, dn);
    checks++; if (res !== 32'hFFFFFFFA) begin errors++; $display("FAIL div_negb_result got %h exp fffffffa", res); end
    do_op(3'b110, 32'd20, 32'hFFFFFFFD, lat, res, sh, sd, dn);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL rem_negb_result got %h exp 00000002", res); end
  endtask

  task automatic test_special();
    int lat, sh; logic [31:0] res; logic sd, dn;
    do_op(3'b101, 32'd123, 32'd0, lat, res, sh, sd, dn);
    checks++; if (lat !== 1) begin errors++; $display("FAIL divu_zero_latency got %0d exp 1", lat); end
    checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero_result got %h exp ffffffff", res); end
    checks++; if (sh !== 1) begin errors++; $display("FAIL divu_zero_stall got %0d exp 1", sh); end
    do_op(3'b110, 32'd5, 32'd0, lat, res, sh, sd, dn);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL rem_zero_result got %h exp 00000005", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL rem_zero_latency got %0d exp 1", lat); end
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, lat, res, sh, sd, dn);
    checks++; if (res !== 32'h80000000) begin errors++; $display("FAIL div_ovf_result got %h exp 80000000", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_ovf_latency got %0d exp 1", lat); end
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, lat, res, sh, sd, dn);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_ovf_result got %h exp 00000000", res); end
  endtask

  task automatic test_flush();
    int lat, sh; logic [31:0] res; logic sd, dn;
    do_op(3'b101, 32'd100, 32'd7, lat, res, sh, sd, dn);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done_during got %b exp 0", done); end
    @(posedge clk); #1 flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done_after got %b exp 0", done); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_result_held got %h exp 0000000e", result); end
    #1;
    do_op(3'b000, 32'd6, 32'd7, lat, res, sh, sd, dn);
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL post_flush_result got %h exp 0000002a", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL post_flush_latency got %0d exp 33", lat); end
    // start together with flush in IDLE is ignored
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; op_a = 32'd9; op_b = 32'd0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL start_flush_stall got %b exp 0", stall); end
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_busy got %b exp 0", busy); end
    checks++; if (result !== 32'd42) begin errors++; $display("FAIL start_flush_result got %h exp 0000002a", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int d1_cyc = -1, d2_cyc = -1;
    logic [31:0] d1_res = '0, d2_res = '0;
    logic stall33 = 1'b1, stall34 = 1'b0, busy34 = 1'b1, busy35 = 1'b0;
    start = 1'b1; flush = 1'b0; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
    for (int c = 0; c < 75; c++) begin
      if (c == 1) funct3 = 3'b111;
      #1;
      if (c == 33) stall33 = stall;
      if (c == 34) begin stall34 = stall; busy34 = busy; end
      if (c == 35) busy35 = busy;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin d1_cyc = c; d1_res = result; end
        else begin d2_cyc = c; d2_res = result; end
      end
      if (done_cnt == 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (d1_cyc !== 33) begin errors++; $display("FAIL b2b_first_done_cycle got %0d exp 33", d1_cyc); end
    checks++; if (d1_res !== 32'd14) begin errors++; $display("FAIL b2b_first_result got %h exp 0000000e", d1_res); end
    checks++; if (stall33 !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_done got %b exp 0", stall33); end
    checks++; if (stall34 !== 1'b1) begin errors++; $display("FAIL b2b_stall_reaccept got %b exp 1", stall34); end
    checks++; if (busy34 !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle got %b exp 0", busy34); end
    checks++; if (busy35 !== 1'b1) begin errors++; $display("FAIL b2b_busy_run got %b exp 1", busy35); end
    checks++; if (d2_cyc !== 67) begin errors++; $display("FAIL b2b_second_done_cycle got %0d exp 67", d2_cyc); end
    checks++; if (d2_res !== 32'd2) begin errors++; $display("FAIL b2b_second_result got %h exp 00000002", d2_res); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, sh; logic [31:0] res; logic sd, dn;
    start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b exp 0", stall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h exp 00000000", result); end
    #1;
    do_op(3'b011, 32'h00010000, 32'h00010000, lat, res, sh, sd, dn);
    checks++; if (res !== 32'h1) begin errors++; $display("FAIL post_reset_result got %h exp 00000001", res); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
